// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver: the frame state
// encoding, the number of data bits per frame and the line levels.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Width of a counter that indexes the data bits of one frame
  localparam int BIT_INDEX_W = $clog2(DATA_BITS);

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_div.sv
// -----------------------------------------------------------------------------
// uart_baud_div
// Restartable bit-period divider. Counts clk cycles from 0 to CLKS_PER_BIT-1
// and flags the last cycle of every bit period.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset, clears the count
//   restart - forces the count back to 0 (a new frame begins)
//   bit_end - high during the last clk of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_div #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  // Count through one bit period and wrap; a restart realigns the period so
  // the first bit of a new frame gets its full length.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_count <= '0;
    end else if (r_count == LAST_COUNT) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bit_end = (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
// 8N1 UART transmit framer with a one-byte holding register so a second byte
// can be queued while a frame is on the line, giving back-to-back frames.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset, aborts any frame
//   data_in   - byte to send, sampled only when accepted
//   valid_in  - a byte is offered on data_in
//   ready_out - the block can accept a byte this cycle (hold register empty)
//   tx        - registered serial line, idle high
//   busy      - a frame is on the line
//   Done      - one-cycle pulse in the last clk of each stop bit
// -----------------------------------------------------------------------------
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy,
  output logic       Done
);

  localparam logic [BIT_INDEX_W-1:0] LAST_DATA_BIT = BIT_INDEX_W'(DATA_BITS - 1);

  uart_state_e r_state;
  uart_state_e w_stateNext;

  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_hold;
  logic                   r_holdFull;
  logic [BIT_INDEX_W-1:0] r_bitCount;
  logic                   r_tx;

  logic w_bitEnd;
  logic w_accept;
  logic w_load;
  logic w_loadFromHold;
  logic w_holdWrite;

  assign ready_out = !r_holdFull;
  assign w_accept  = valid_in && ready_out;
  assign busy      = (r_state != IDLE);
  assign tx        = r_tx;

  uart_baud_div #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baudDiv (
    .clk    (clk),
    .reset  (reset),
    .restart(w_load),
    .bit_end(w_bitEnd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and control decode. In the last stop cycle the held byte wins;
  // only with an empty hold can a byte offered in that cycle go straight into
  // the shifter, so the next start bit follows with no idle gap. An accept
  // anywhere else mid-frame lands in the holding register.
  always_comb begin
    w_stateNext    = r_state;
    w_load         = 1'b0;
    w_loadFromHold = 1'b0;
    w_holdWrite    = 1'b0;
    Done           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_stateNext = START;
        end
      end
      START: begin
        w_holdWrite = w_accept;
        if (w_bitEnd) begin
          w_stateNext = DATA;
        end
      end
      DATA: begin
        w_holdWrite = w_accept;
        if (w_bitEnd && (r_bitCount == LAST_DATA_BIT)) begin
          w_stateNext = STOP;
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          Done = 1'b1;
          if (r_holdFull) begin
            w_load         = 1'b1;
            w_loadFromHold = 1'b1;
            w_stateNext    = START;
          end else if (w_accept) begin
            w_load      = 1'b1;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_holdWrite = w_accept;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Shifter, bit counter and line register. The line only changes on a load
  // or at the end of a bit period, so it never moves mid-bit. Each data bit
  // is taken from the bottom of the shifter as the previous bit ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx       <= LINE_IDLE;
      r_shift    <= '0;
      r_bitCount <= '0;
    end else if (w_load) begin
      r_tx       <= START_BIT;
      r_shift    <= w_loadFromHold ? r_hold : data_in;
      r_bitCount <= '0;
    end else if (w_bitEnd) begin
      case (r_state)
        START: begin
          r_tx       <= r_shift[0];
          r_shift    <= r_shift >> 1;
          r_bitCount <= '0;
        end
        DATA: begin
          if (r_bitCount == LAST_DATA_BIT) begin
            r_tx <= STOP_BIT;
          end else begin
            r_tx       <= r_shift[0];
            r_shift    <= r_shift >> 1;
            r_bitCount <= r_bitCount + 1'b1;
          end
        end
        STOP: begin
          r_tx <= LINE_IDLE;
        end
        default: begin
          r_tx <= LINE_IDLE;
        end
      endcase
    end
  end

  // Holding register. It can only be written while ready_out is high, and it
  // empties at the moment its byte moves into the shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold     <= '0;
      r_holdFull <= 1'b0;
    end else if (w_holdWrite) begin
      r_hold     <= data_in;
      r_holdFull <= 1'b1;
    end else if (w_loadFromHold) begin
      r_holdFull <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
// Drives bytes into uart_tx_framer and decodes the serial line back into
// bytes, comparing each frame against the bytes the driver saw accepted.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

  localparam int CPB = 4;
  localparam int FRAME_BITS = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       tx;
  logic       busy;
  logic       Done;

  uart_tx_framer #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .tx       (tx),
    .busy     (busy),
    .Done     (Done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bytes accepted by the DUT and not yet seen starting on the line
  logic [7:0] expQ[$];

  // Line decoder state
  bit         inFrame = 1'b0;
  int         bitIdx = 0;
  int         sampleCnt = 0;
  int         badSamples = 0;
  int         idleRun = 0;
  int         lastGap = -1;
  int         framesDone = 0;
  logic [7:0] expByte = 8'h00;
  logic [7:0] rxByte = 8'h00;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock of stimulus: inputs change just after the falling edge, and the
  // accept decision is taken just before the rising edge where the DUT samples.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r, output bit acc);
    @(negedge clk);
    #1;
    valid_in = v;
    data_in  = d;
    reset    = r;
    #3;
    acc = v && ready_out && !r;
    if (acc) expQ.push_back(d);
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, acc);
  endtask

  // Line decoder: watches the line on falling edges, frames it as a receiver
  // would, and checks every sample of a frame against the expected 8N1 shape.
  // Between frames the line must be idle high, not busy, and ready.
  always @(negedge clk) begin
    if (reset) begin
      inFrame = 1'b0;
      expQ.delete();
      idleRun = 0;
    end else begin
      if (!inFrame) begin
        if (tx == 1'b0) begin
          checkOutput("start bit has a queued byte", int'(expQ.size() > 0), 1);
          if (expQ.size() > 0) expByte = expQ.pop_front();
          else expByte = 8'h00;
          lastGap    = idleRun;
          idleRun    = 0;
          inFrame    = 1'b1;
          bitIdx     = 0;
          sampleCnt  = 0;
          badSamples = 0;
          rxByte     = 8'h00;
        end else begin
          checkOutput("idle {tx,busy,Done,ready_out}", int'({tx, busy, Done, ready_out}), 9);
          idleRun++;
        end
      end
      if (inFrame) begin
        logic expBit;
        if (bitIdx == 0) expBit = 1'b0;
        else if (bitIdx == FRAME_BITS - 1) expBit = 1'b1;
        else expBit = expByte[bitIdx-1];
        if (tx !== expBit) badSamples++;
        if (busy !== 1'b1) badSamples++;
        if (Done !== ((bitIdx == FRAME_BITS - 1) && (sampleCnt == CPB - 1))) badSamples++;
        if (ready_out !== (expQ.size() == 0)) badSamples++;
        if ((bitIdx >= 1) && (bitIdx <= 8) && (sampleCnt == CPB / 2)) rxByte[bitIdx-1] = tx;
        sampleCnt++;
        if (sampleCnt == CPB) begin
          sampleCnt = 0;
          bitIdx++;
          if (bitIdx == FRAME_BITS) begin
            inFrame = 1'b0;
            checkOutput("received byte", int'(rxByte), int'(expByte));
            checkOutput("frame bad samples", badSamples, 0);
            framesDone++;
          end
        end
      end
    end
  end

  // Absolute bound on the run in case the stimulus never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by random traffic.
  initial begin
    bit         acc;
    int         f0;
    int         n;
    int         idx;
    logic [7:0] seq[3];

    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, acc);
    checkOutput("reset tx", int'(tx), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset ready_out", int'(ready_out), 1);
    checkOutput("reset Done", int'(Done), 0);

    // Single byte from idle
    f0 = framesDone;
    applyStimulus(1'b1, 8'hA5, 1'b0, acc);
    checkOutput("A5 accepted in idle", int'(acc), 1);
    idleCycles(50);
    checkOutput("A5 frame count", framesDone - f0, 1);

    // Second byte queued while the first is on the line
    f0 = framesDone;
    applyStimulus(1'b1, 8'h00, 1'b0, acc);
    checkOutput("00 accepted in idle", int'(acc), 1);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      applyStimulus(1'b1, 8'hFF, 1'b0, acc);
      n++;
    end
    checkOutput("FF accepted while sending", int'(acc), 1);
    idleCycles(90);
    checkOutput("00/FF frame count", framesDone - f0, 2);
    checkOutput("00/FF gap between frames", lastGap, 0);

    // valid_in held high, data advancing only on accept
    f0 = framesDone;
    seq[0] = 8'h11;
    seq[1] = 8'h22;
    seq[2] = 8'h33;
    idx = 0;
    n = 0;
    while (idx < 3 && n < 300) begin
      applyStimulus(1'b1, seq[idx], 1'b0, acc);
      if (acc) idx++;
      n++;
    end
    checkOutput("three held-valid bytes accepted", idx, 3);
    idleCycles(90);
    checkOutput("held-valid frame count", framesDone - f0, 3);
    checkOutput("held-valid gap before third frame", lastGap, 0);

    // Accept in the last stop cycle with the hold empty
    f0 = framesDone;
    applyStimulus(1'b1, 8'hC3, 1'b0, acc);
    checkOutput("C3 accepted in idle", int'(acc), 1);
    idleCycles(CPB * FRAME_BITS - 1);
    applyStimulus(1'b1, 8'h96, 1'b0, acc);
    checkOutput("Done in last stop cycle", int'(Done), 1);
    checkOutput("96 accepted in last stop cycle", int'(acc), 1);
    idleCycles(50);
    checkOutput("C3/96 frame count", framesDone - f0, 2);
    checkOutput("C3/96 gap between frames", lastGap, 0);

    // Reset mid-frame with a byte held; the byte offered with reset is lost
    f0 = framesDone;
    applyStimulus(1'b1, 8'h3C, 1'b0, acc);
    checkOutput("3C accepted in idle", int'(acc), 1);
    applyStimulus(1'b1, 8'h5A, 1'b0, acc);
    checkOutput("5A accepted into hold", int'(acc), 1);
    idleCycles(16);
    applyStimulus(1'b1, 8'h77, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, acc);
    checkOutput("after reset tx", int'(tx), 1);
    checkOutput("after reset busy", int'(busy), 0);
    checkOutput("after reset ready_out", int'(ready_out), 1);
    idleCycles(60);
    checkOutput("no frame completes after reset", framesDone - f0, 0);

    // Random traffic: valid toggling, data changing while not ready, rare reset
    for (int i = 0; i < 800; i++) begin
      bit         v;
      bit         r;
      logic [7:0] d;
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      r = ($urandom_range(0, 299) == 0);
      applyStimulus(v, d, r, acc);
    end
    idleCycles(100);
    checkOutput("all accepted bytes transmitted", expQ.size(), 0);
    checkOutput("line decoder idle at end", int'(inFrame), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per bit period (legal minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port data_in, input, 8, byte to transmit, sampled only on accept.
REQ-005 SHALL have port valid_in, input, 1, a byte is offered on data_in.
REQ-006 SHALL have port ready_out, output, 1, the block can accept a byte this cycle.
REQ-007 SHALL have port tx, output, 1, serial line, registered, idle high.
REQ-008 SHALL have port busy, output, 1, high while a frame is on the line (any state other than IDLE).
REQ-009 SHALL have port Done, output, 1, one-cycle pulse in the last clk of each stop bit.

Function
REQ-010 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit held exactly CLKS_PER_BIT clks.
REQ-011 SHALL define accept as valid_in && ready_out at a rising edge; no other condition consumes a byte.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP with transitions: IDLE->START on a load; START->DATA after one bit period; DATA->STOP after 8th bit period; STOP->START on a load in its last cycle, else STOP->IDLE.
REQ-013 SHALL contain an 8-bit shifter, a 3-bit data bit counter and a bit-period counter of width clog2(CLKS_PER_BIT), which restarts at 0 on every load.
REQ-014 SHALL contain a one-byte holding register with flag hold_full; ready_out SHALL equal !hold_full combinationally.
REQ-015 SHALL, on accept in IDLE, load data_in directly into the shifter (bypass); tx goes low on the next clk (latency 1 cycle).
REQ-016 SHALL, on accept in START, DATA or STOP, write data_in into the holding register and set hold_full.
REQ-017 SHALL, in the last cycle of STOP: if hold_full, load the shifter from the holding register and clear hold_full; else if accept, load from data_in; else go to IDLE.
REQ-018 SHALL produce back-to-back frames with zero idle clks between a stop bit and the next start bit when a byte is pending.
REQ-019 SHALL ignore valid_in while ready_out is low; data_in is not sampled and the holding register is unchanged.
REQ-020 SHALL raise Done in the last STOP cycle regardless of whether a next frame follows.
REQ-021 SHALL keep tx high in IDLE and never glitch tx mid-bit; tx changes only at bit-period boundaries or on reset.

Reset
REQ-022 SHALL, when reset is high at a rising edge, set state=IDLE, tx=1, busy=0, Done=0, hold_full=0 (ready_out=1), and clear all counters and the shifter.
REQ-023 SHALL abort any frame in progress on reset, discard the held byte, and drive tx=1 from the next clk.
REQ-024 SHALL give reset priority over accept in the same cycle; that byte is lost.

Structure
REQ-025 SHALL take state encoding (IDLE, START, DATA, STOP), DATA_BITS=8 and LINE_IDLE=1 from shared package uart_pkg, also usable by the receiver.
REQ-026 SHALL place the restartable bit-period counter in sub-module uart_baud_div (inputs clk, reset, restart; output bit_end pulse).

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte 0xA5 accepted in IDLE at cycle 0 -> tx from cycle 1: 0,1,0,1,0,0,1,0,1,1, each bit 4 clks; Done high at cycle 40 only; busy low from cycle 41.
REQ-028 0x00 accepted in IDLE, 0xFF accepted while sending 0x00 -> ready_out low until last STOP cycle of frame 1; 80 contiguous clks of frames, no idle gap; two Done pulses 40 clks apart.
REQ-029 valid_in held high with 0x11, 0x22, 0x33 changing only on accept -> exactly three frames in order, ready_out low while hold_full, no byte duplicated or dropped.
REQ-030 Reset asserted at cycle 18 of a 0x3C frame with a byte held -> tx=1, busy=0, ready_out=1 from cycle 19; no Done; no further frame starts.
REQ-031 Accept in last STOP cycle with hold empty -> next start bit begins the following clk, zero gap.
REQ-032 valid_in toggled while ready_out=0 with differing data_in -> transmitted bytes match only the accepted values.
